// File: rtl/camera_pkg.sv
// Shared camera constants: exposure limits, exposure width, and the
// exposure-control FSM state codes used by neighbouring blocks and benches.
package camera_pkg;

    localparam int EXP_W       = 5;   // width of exposure setting and ms counter
    localparam int EXP_MIN     = 2;   // ms
    localparam int EXP_MAX     = 30;  // ms, must fit in EXP_W bits
    localparam int EXP_DEFAULT = 2;   // ms, value after reset

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_EXPOSURE = 2'b01,
        ST_READOUT  = 2'b10
    } cam_state_e;

    // Saturating +/-1 step of the exposure setting. Simultaneous inc and dec
    // cancel; a step that would leave [lo, hi] is clamped to the limit.
    function automatic logic [EXP_W-1:0] exp_step(
        input logic [EXP_W-1:0] cur,
        input logic             inc,
        input logic             dec,
        input logic [EXP_W-1:0] lo,
        input logic [EXP_W-1:0] hi
    );
        logic [EXP_W-1:0] nxt;
        nxt = cur;
        if (inc && !dec) begin
            nxt = (cur >= hi) ? hi : cur + EXP_W'(1);
        end else if (dec && !inc) begin
            nxt = (cur <= lo) ? lo : cur - EXP_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ovf_counter.sv
// Generic up-counter with enable, synchronous clear and a runtime terminal
// value. Emits a registered one-shot pulse on the step that reaches the
// terminal value. WRAP=1 returns to zero after the terminal value (prescaler);
// WRAP=0 holds at the terminal value so it can never pulse twice.
module ovf_counter #(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] term,
    output logic             at_term,   // count has reached (or passed) term
    output logic             term_stb,  // enabled step taken while at term (wrap event)
    output logic             pulse      // registered: last step reached term
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             pulse_q, pulse_d;
    logic             at_or_past;

    // Next count; clear wins over enable, and stepping into term fires the pulse.
    always_comb begin
        at_or_past = (count_q >= term);
        count_d    = count_q;
        pulse_d    = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            if (at_or_past) begin
                count_d = WRAP ? '0 : count_q;
            end else begin
                count_d = count_q + WIDTH'(1);
                pulse_d = (count_d == term);
            end
        end
    end

    // Counter and pulse state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            count_q <= count_d;
            pulse_q <= pulse_d;
        end
    end

    assign at_term  = at_or_past;
    assign term_stb = en && !clr && at_or_past;
    assign pulse    = pulse_q;

endmodule

// File: rtl/exposure_timer.sv
// Exposure timer: holds the user exposure setting (Exp_Inc/Exp_Dec), times
// the exposure phase in ms ticks and the readout phase in clock cycles, and
// returns single-cycle done pulses (Ovf5 exposure, Ovf4 readout) to the FSM.
module exposure_timer
    import camera_pkg::*;
#(
    parameter int CLK_DIV     = 1000,
    parameter int EXP_MIN     = camera_pkg::EXP_MIN,
    parameter int EXP_MAX     = camera_pkg::EXP_MAX,
    parameter int EXP_DEFAULT = camera_pkg::EXP_DEFAULT,
    parameter int RDO_LEN     = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Exp_Inc,
    input  logic             Exp_Dec,
    input  logic             Expose,
    input  logic             ADC,
    output logic             Ovf5,
    output logic             Ovf4,
    output logic [EXP_W-1:0] Exp_Time
);

    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RDO_W = (RDO_LEN > 0) ? $clog2(RDO_LEN + 1) : 1;

    localparam logic [PRE_W-1:0] PRE_TERM = PRE_W'(CLK_DIV - 1);
    localparam logic [RDO_W-1:0] RDO_TERM = RDO_W'(RDO_LEN);
    localparam logic [EXP_W-1:0] EXP_LO   = EXP_W'(EXP_MIN);
    localparam logic [EXP_W-1:0] EXP_HI   = EXP_W'(EXP_MAX);
    localparam logic [EXP_W-1:0] EXP_DEF  = EXP_W'(EXP_DEFAULT);

    // Exposure setting and button edge registers
    logic [EXP_W-1:0] exp_time_q, exp_time_d;
    logic             inc_q, inc_d;
    logic             dec_q, dec_d;
    logic             inc_edge, dec_edge, buttons_live;

    // Exposure snapshot: captured on the first Expose cycle, held until Expose drops
    logic [EXP_W-1:0] snap_q, snap_d, snap_eff;
    logic             expose_seen_q, expose_seen_d;

    // Counter interconnect
    logic pre_en, pre_clr, pre_wrap, pre_done, pre_pulse;
    logic ms_clr, ms_done, ms_term_stb, ms_pulse;
    logic rdo_en, rdo_clr, rdo_done, rdo_term_stb, rdo_pulse;

    // Button edges only count while the FSM is idle; other edges are dropped.
    always_comb begin
        inc_d        = Exp_Inc;
        dec_d        = Exp_Dec;
        inc_edge     = Exp_Inc && !inc_q;
        dec_edge     = Exp_Dec && !dec_q;
        buttons_live = !Expose && !ADC;
        exp_time_d   = exp_time_q;
        if (buttons_live) begin
            exp_time_d = exp_step(exp_time_q, inc_edge, dec_edge, EXP_LO, EXP_HI);
        end
    end

    // On the first Expose cycle the live setting is used directly as the target,
    // so the target is valid from the very first counted cycle.
    always_comb begin
        expose_seen_d = Expose;
        snap_eff      = expose_seen_q ? snap_q : exp_time_q;
        snap_d        = Expose ? snap_eff : '0;
    end

    // Setting, button history and snapshot registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            exp_time_q    <= EXP_DEF;
            inc_q         <= 1'b0;
            dec_q         <= 1'b0;
            snap_q        <= '0;
            expose_seen_q <= 1'b0;
        end else begin
            exp_time_q    <= exp_time_d;
            inc_q         <= inc_d;
            dec_q         <= dec_d;
            snap_q        <= snap_d;
            expose_seen_q <= expose_seen_d;
        end
    end

    // Exposure runs whenever Expose is high; once the ms counter has reached the
    // target the prescaler freezes too, so everything holds until Expose drops.
    // Readout is suppressed entirely while Expose is (illegally) also high.
    always_comb begin
        pre_en  = Expose && !ms_done;
        pre_clr = !Expose;
        ms_clr  = !Expose;
        rdo_en  = ADC && !Expose;
        rdo_clr = !ADC || Expose;
    end

    ovf_counter #(
        .WIDTH (PRE_W),
        .WRAP  (1'b1)
    ) u_prescaler (
        .clk      (Clk),
        .rst_n    (Reset),
        .en       (pre_en),
        .clr      (pre_clr),
        .term     (PRE_TERM),
        .at_term  (pre_done),
        .term_stb (pre_wrap),
        .pulse    (pre_pulse)
    );

    ovf_counter #(
        .WIDTH (EXP_W),
        .WRAP  (1'b0)
    ) u_ms_counter (
        .clk      (Clk),
        .rst_n    (Reset),
        .en       (pre_wrap),
        .clr      (ms_clr),
        .term     (snap_eff),
        .at_term  (ms_done),
        .term_stb (ms_term_stb),
        .pulse    (ms_pulse)
    );

    ovf_counter #(
        .WIDTH (RDO_W),
        .WRAP  (1'b0)
    ) u_readout_counter (
        .clk      (Clk),
        .rst_n    (Reset),
        .en       (rdo_en),
        .clr      (rdo_clr),
        .term     (RDO_TERM),
        .at_term  (rdo_done),
        .term_stb (rdo_term_stb),
        .pulse    (rdo_pulse)
    );

    // Status lines of the generic counter that this block has no use for.
    logic unused_ok;
    assign unused_ok = ^{pre_done, pre_pulse, ms_term_stb, rdo_done, rdo_term_stb};

    assign Ovf5     = ms_pulse;
    assign Ovf4     = rdo_pulse;
    assign Exp_Time = exp_time_q;

endmodule

// File: doc/exposure_timer.md
Name: exposure_timer

Overview:
- Timing stage directly upstream of the exposure-control state machine.
- Holds the user-adjustable exposure time, set by the Exp_Inc/Exp_Dec buttons.
- Times the exposure phase and the readout phase.
- Produces the single-cycle overflow pulses Ovf5 (exposure done) and Ovf4 (readout done) that the FSM consumes.
- Takes the FSM's Expose and ADC outputs back as phase enables.

Parameters:
- CLK_DIV, 1000: Clk cycles per 1 ms tick.
- EXP_MIN, 2: minimum exposure, ms.
- EXP_MAX, 30: maximum exposure, ms.
- EXP_DEFAULT, 2: exposure after reset, ms.
- RDO_LEN, 16: readout duration, Clk cycles.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- Exp_Inc  in  1  increase-exposure button, synchronous level.
- Exp_Dec  in  1  decrease-exposure button, synchronous level.
- Expose  in  1  exposure phase active (from FSM).
- ADC  in  1  readout phase active (from FSM).
- Ovf5  out  1  exposure-complete pulse.
- Ovf4  out  1  readout-complete pulse.
- Exp_Time  out  5  current exposure setting, ms, unsigned.

Behaviour:
- Reset low (async): Exp_Time=EXP_DEFAULT, Ovf5=0, Ovf4=0, all counters 0, edge registers 0. Release is synchronous to the next Clk edge.
- Button handling:
  - Exp_Inc/Exp_Dec are rising-edge detected against a registered copy.
  - An edge is acted on only when Expose=0 and ADC=0. Edges in other states are discarded, not queued.
  - Inc edge: Exp_Time+1, saturating at EXP_MAX.
  - Dec edge: Exp_Time-1, saturating at EXP_MIN.
  - Both edges in the same cycle: no change.
  - Exp_Time updates on the cycle after the edge cycle.
- Exposure timing:
  - While Expose=1, the prescaler counts 0..CLK_DIV-1 and wraps. Each wrap increments the ms counter.
  - Exp_Time is snapshotted on the first cycle Expose is sampled high.
  - Ovf5 is registered. It is high for exactly one cycle, the (snapshot*CLK_DIV)-th Clk cycle in which Expose is sampled high, counting the first as 1.
  - After the pulse, counters hold and Ovf5 stays 0 until Expose drops.
  - Expose=0: prescaler, ms counter and done flag clear synchronously; Ovf5=0.
  - Expose dropping mid-count (FSM reset to Idle) aborts the count with no pulse.
- Readout timing:
  - While ADC=1, the cycle counter increments.
  - Ovf4 is high for one cycle, the RDO_LEN-th cycle in which ADC is sampled high. The counter then holds with no re-pulse.
  - ADC=0 clears the counter.
- Expose=1 and ADC=1 together is illegal. Exposure logic runs normally; the readout counter is held cleared and Ovf4=0.
- Widths:
  - Prescaler: clog2(CLK_DIV) bits.
  - ms counter and Exp_Time: 5 bits, so EXP_MAX must be <= 31.
  - Readout counter: clog2(RDO_LEN+1) bits.
  - Comparisons are unsigned; no counter may wrap past its terminal value.
- Ovf5 and Ovf4 are never high in the same cycle.

Decomposition:
- Shared package camera_pkg holds:
  - EXP_MIN, EXP_MAX, EXP_DEFAULT and the exposure width constant (5);
  - the FSM state codes Idle=2'b00, Exposure=2'b01, Readout=2'b10 for use by benches.
- Sub-module ovf_counter(WIDTH): one generic counter with enable, sync clear, terminal value input and a one-shot terminal pulse. Used for the prescaler, the ms counter and the readout counter.

Test Plan:
1. Reset low mid-exposure, CLK_DIV=4, Expose=1 -> Exp_Time=2, Ovf5=0, Ovf4=0 immediately; after release with Expose=1, Ovf5 pulses on the 8th high cycle.
2. Idle; 30 Exp_Inc pulses, then 31 Exp_Dec pulses -> Exp_Time saturates at 30, then at 2. Inc and Dec rising in the same cycle -> unchanged.
3. Exp_Time=5, CLK_DIV=4, Expose held high 40 cycles -> exactly one Ovf5 pulse, on cycle 20. An Exp_Inc during exposure leaves Exp_Time=5.
4. Expose high 10 cycles then low (Exp_Time=5, CLK_DIV=4) -> no Ovf5. Next Expose restarts from 0 and pulses at cycle 20.
5. ADC high 30 cycles, RDO_LEN=16 -> Ovf4 single pulse on cycle 16. Expose and ADC both high -> Ovf4 never asserts.
6. Closed loop with the FSM: Init=1 -> Exposure -> Ovf5 -> Readout -> Ovf4 -> Idle. Total cycles = Exp_Time*CLK_DIV + RDO_LEN + 2 FSM transition cycles.
